// File: rtl/dat_host_xfer_pkg.sv
// Shared widths, FSM encodings and word-count helper for the host-side DAT transfer sequencer.
// Combinational helpers only; no backpressure of its own.
package dat_host_xfer_pkg;

  localparam int DAT_FIFO_WIDTH      = 32;
  localparam int DAT_BLOCK_SZ_WIDTH  = 12;
  localparam int DAT_BLOCK_CNT_WIDTH = 16;
  localparam int DAT_BYTES_PER_WORD  = 4;
  localparam int DAT_WORDS_WIDTH     = 28;

  localparam logic [2:0] DHX_IDLE     = 3'd0;
  localparam logic [2:0] DHX_TX_FILL  = 3'd1;
  localparam logic [2:0] DHX_TX_WAIT  = 3'd2;
  localparam logic [2:0] DHX_RX_DRAIN = 3'd3;
  localparam logic [2:0] DHX_DONE     = 3'd4;

  typedef logic [DAT_WORDS_WIDTH-1:0] words_t;

  // Words in a transfer: bytes per block rounded up to whole words, times block count.
  function automatic words_t dat_words_total(input words_t sz, input words_t cnt);
    words_t per_blk;
    per_blk = (sz + words_t'(DAT_BYTES_PER_WORD - 1)) / words_t'(DAT_BYTES_PER_WORD);
    return per_blk * cnt;
  endfunction

endpackage

// File: rtl/dat_rx_skid.sv
// Two-entry skid between the rx FIFO (1-cycle read latency) and the output stream; head data from flops.
// Reads are only permitted while stored + in-flight words, net of this cycle's pop, stay below two.
module dat_rx_skid
  import dat_host_xfer_pkg::*;
#(
  parameter int W = DAT_FIFO_WIDTH
) (
  input  logic         host_clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         rd_issue,
  input  logic [W-1:0] rd_dat,
  output logic         can_issue,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready
);

  logic [1:0]   cnt_q, cnt_d;
  logic         inflight_q, inflight_d;
  logic [W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic         push, pop;
  logic [2:0]   occ;

  assign push      = inflight_q;
  assign pop       = (cnt_q != 2'd0) && m_tready;
  assign occ       = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
  assign can_issue = (occ < 3'd2);
  assign m_tvalid  = (cnt_q != 2'd0);
  assign m_tdata   = buf0_q;

  always_comb begin
    cnt_d      = cnt_q;
    inflight_d = rd_issue;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    if (flush) begin
      cnt_d      = 2'd0;
      inflight_d = 1'b0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (cnt_q == 2'd1) begin
            buf0_d = rd_dat;
          end else begin
            buf0_d = buf1_q;
            buf1_d = rd_dat;
          end
        end
        2'b10: begin
          if (cnt_q == 2'd0) buf0_d = rd_dat;
          else               buf1_d = rd_dat;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          buf0_d = buf1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge host_clk) begin
    if (rst) begin
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule

// File: rtl/dat_host_xfer.sv
// Host-clock sequencer: stream -> tx FIFO then tx_data_init, or rx_data_init then rx FIFO -> stream.
// TX writes are same-cycle with the stream handshake (s_tready = !tx_buf_full); RX goes through a 2-entry skid.
module dat_host_xfer
  import dat_host_xfer_pkg::*;
#(
  parameter int FIFO_WIDTH      = DAT_FIFO_WIDTH,
  parameter int BLOCK_SZ_WIDTH  = DAT_BLOCK_SZ_WIDTH,
  parameter int BLOCK_CNT_WIDTH = DAT_BLOCK_CNT_WIDTH
) (
  input  logic                       host_clk,
  input  logic                       rst,
  input  logic                       tx_start,
  input  logic                       rx_start,
  input  logic                       abort,
  input  logic [BLOCK_SZ_WIDTH-1:0]  block_sz,
  input  logic [BLOCK_CNT_WIDTH-1:0] block_cnt,
  input  logic [FIFO_WIDTH-1:0]      s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic [FIFO_WIDTH-1:0]      m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  input  logic                       tx_buf_full,
  output logic                       tx_buf_wr_host,
  output logic [FIFO_WIDTH-1:0]      tx_buf_din,
  input  logic                       rx_buf_empty,
  output logic                       rx_buf_rd_host,
  input  logic [FIFO_WIDTH-1:0]      rx_buf_dout,
  input  logic                       tf_finished,
  output logic                       tx_data_init,
  output logic                       rx_data_init,
  output logic                       busy,
  output logic                       xfer_done,
  output logic                       xfer_err,
  output logic [DAT_WORDS_WIDTH-1:0] words_left
);

  logic [2:0] state_q, state_d;
  words_t     words_left_q, words_left_d;
  words_t     reads_left_q, reads_left_d;
  logic       err_q, err_d;
  logic       tf_seen_q, tf_seen_d;
  logic       tx_first_q, tx_first_d;
  logic       tx_init_q, tx_init_d;
  logic       rx_init_q, rx_init_d;

  words_t     total_words;
  logic       zero_len, in_fill, in_drain, abort_hit;
  logic       tx_wr, rx_rd, rx_hs, skid_flush, skid_can_issue;

  assign total_words = dat_words_total(DAT_WORDS_WIDTH'(block_sz), DAT_WORDS_WIDTH'(block_cnt));
  assign zero_len    = (block_sz == '0) || (block_cnt == '0);
  assign in_fill     = (state_q == DHX_TX_FILL);
  assign in_drain    = (state_q == DHX_RX_DRAIN);
  assign abort_hit   = abort && (in_fill || in_drain || state_q == DHX_TX_WAIT);

  assign s_tready       = in_fill && !tx_buf_full && !abort && (words_left_q != '0);
  assign tx_wr          = s_tvalid && s_tready;
  assign tx_buf_wr_host = tx_wr;
  assign tx_buf_din     = tx_wr ? s_tdata : '0;

  assign rx_rd          = in_drain && !abort && (reads_left_q != '0) && !rx_buf_empty && skid_can_issue;
  assign rx_buf_rd_host = rx_rd;
  assign rx_hs          = in_drain && m_tvalid && m_tready;
  // Skid is held empty outside RX so a stale in-flight word can never leak into the next transfer.
  assign skid_flush     = abort_hit || !in_drain;

  dat_rx_skid #(.W(FIFO_WIDTH)) u_skid (
    .host_clk  (host_clk),
    .rst       (rst),
    .flush     (skid_flush),
    .rd_issue  (rx_rd),
    .rd_dat    (rx_buf_dout),
    .can_issue (skid_can_issue),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready)
  );

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    reads_left_d = reads_left_q;
    err_d        = err_q;
    tf_seen_d    = tf_seen_q;
    tx_first_d   = tx_first_q;
    tx_init_d    = 1'b0;
    rx_init_d    = 1'b0;
    case (state_q)
      DHX_IDLE: begin
        err_d      = 1'b0;
        tf_seen_d  = 1'b0;
        tx_first_d = 1'b0;
        if (tx_start || rx_start) begin
          words_left_d = total_words;
          reads_left_d = total_words;
          if (zero_len) begin
            state_d = DHX_DONE;
            err_d   = 1'b1;
          end else if (tx_start) begin
            state_d = DHX_TX_FILL;
          end else begin
            state_d   = DHX_RX_DRAIN;
            rx_init_d = 1'b1;
          end
        end
      end
      DHX_TX_FILL: begin
        if (tf_finished) tf_seen_d = 1'b1;
        if (tx_wr) begin
          words_left_d = words_left_q - 1'b1;
          if (!tx_first_q) begin
            tx_first_d = 1'b1;
            tx_init_d  = 1'b1;
          end
          if (words_left_q == words_t'(1)) state_d = DHX_TX_WAIT;
        end
      end
      DHX_TX_WAIT: begin
        if (tf_finished || tf_seen_q) state_d = DHX_DONE;
      end
      DHX_RX_DRAIN: begin
        if (rx_rd) reads_left_d = reads_left_q - 1'b1;
        if (rx_hs) begin
          words_left_d = words_left_q - 1'b1;
          if (words_left_q == words_t'(1)) state_d = DHX_DONE;
        end
      end
      DHX_DONE: begin
        state_d = DHX_IDLE;
      end
      default: state_d = DHX_IDLE;
    endcase
    if (abort_hit) begin
      state_d   = DHX_DONE;
      err_d     = 1'b1;
      tx_init_d = 1'b0;
    end
  end

  always_ff @(posedge host_clk) begin
    if (rst) begin
      state_q      <= DHX_IDLE;
      words_left_q <= '0;
      reads_left_q <= '0;
      err_q        <= 1'b0;
      tf_seen_q    <= 1'b0;
      tx_first_q   <= 1'b0;
      tx_init_q    <= 1'b0;
      rx_init_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      reads_left_q <= reads_left_d;
      err_q        <= err_d;
      tf_seen_q    <= tf_seen_d;
      tx_first_q   <= tx_first_d;
      tx_init_q    <= tx_init_d;
      rx_init_q    <= rx_init_d;
    end
  end

  assign busy         = (state_q != DHX_IDLE);
  assign xfer_done    = (state_q == DHX_DONE);
  assign xfer_err     = xfer_done && err_q;
  assign tx_data_init = tx_init_q;
  assign rx_data_init = rx_init_q;
  assign words_left   = words_left_q;

endmodule

// File: tb/tb_dat_host_xfer.sv
// Directed scenarios with random payloads, random stream/FIFO timing and a queue-based FIFO/stream model.
module tb_dat_host_xfer;

  logic        host_clk = 1'b0;
  logic        rst, tx_start, rx_start, abort;
  logic [11:0] block_sz;
  logic [15:0] block_cnt;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready;
  logic        tx_buf_full, tx_buf_wr_host;
  logic [31:0] tx_buf_din;
  logic        rx_buf_empty, rx_buf_rd_host;
  logic [31:0] rx_buf_dout;
  logic        tf_finished, tx_data_init, rx_data_init, busy, xfer_done, xfer_err;
  logic [27:0] words_left;

  dat_host_xfer dut (
    .host_clk(host_clk), .rst(rst), .tx_start(tx_start), .rx_start(rx_start), .abort(abort),
    .block_sz(block_sz), .block_cnt(block_cnt),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .tx_buf_full(tx_buf_full), .tx_buf_wr_host(tx_buf_wr_host), .tx_buf_din(tx_buf_din),
    .rx_buf_empty(rx_buf_empty), .rx_buf_rd_host(rx_buf_rd_host), .rx_buf_dout(rx_buf_dout),
    .tf_finished(tf_finished), .tx_data_init(tx_data_init), .rx_data_init(rx_data_init),
    .busy(busy), .xfer_done(xfer_done), .xfer_err(xfer_err), .words_left(words_left)
  );

  always #5 host_clk = ~host_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] src_q[$], tx_exp[$], txgot[$], rxq[$], rx_exp[$], mgot[$];
  int  n_wr, n_rd, n_txinit, n_rxinit, n_done, n_err;
  int  first_wr_cyc, txinit_cyc, rxinit_cyc, done_cyc, last_beat_cyc;
  int  stab_viol = 0, underflow = 0;
  bit  p_rst, p_tx, p_rx, p_abort, p_tf;
  int  valid_pct = 100, full_pct = 0, ready_mode = 0;
  bit  full_force = 0;
  bit  rd_pend = 0, prev_hold = 0;
  logic [31:0] rd_word = '0, prev_dat = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int q_diff(input logic [31:0] a[$], input logic [31:0] b[$]);
    int d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  // One cycle: drive at the falling edge, observe just after, then let the rising edge act.
  task automatic step();
    @(negedge host_clk);
    if (rd_pend) rx_buf_dout = rd_word;
    rx_buf_empty = (rxq.size() == 0);
    rst = p_rst; tx_start = p_tx; rx_start = p_rx; abort = p_abort; tf_finished = p_tf;
    p_tx = 0; p_rx = 0; p_abort = 0; p_tf = 0;
    tx_buf_full = full_force || ($urandom_range(99) < full_pct);
    s_tvalid = (src_q.size() != 0) && ($urandom_range(99) < valid_pct);
    s_tdata  = (src_q.size() != 0) ? src_q[0] : $urandom();
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(1));
    endcase
    #1;
    if (s_tvalid && s_tready) void'(src_q.pop_front());
    if (tx_buf_wr_host === 1'b1) begin
      if (n_wr == 0) first_wr_cyc = cyc;
      n_wr++;
      txgot.push_back(tx_buf_din);
    end
    if (rx_buf_rd_host === 1'b1) begin
      if (rxq.size() == 0) underflow++;
      else rd_word = rxq.pop_front();
      n_rd++;
      rd_pend = 1;
    end else rd_pend = 0;
    if (prev_hold && (m_tvalid !== 1'b1 || m_tdata !== prev_dat)) stab_viol++;
    prev_hold = (m_tvalid === 1'b1) && !m_tready && !abort && !rst;
    prev_dat  = m_tdata;
    if (m_tvalid === 1'b1 && m_tready) begin mgot.push_back(m_tdata); last_beat_cyc = cyc; end
    if (tx_data_init === 1'b1) begin n_txinit++; txinit_cyc = cyc; end
    if (rx_data_init === 1'b1) begin n_rxinit++; rxinit_cyc = cyc; end
    if (xfer_done === 1'b1) begin n_done++; done_cyc = cyc; end
    if (xfer_err === 1'b1) n_err++;
    cyc++;
  endtask

  task automatic clear_obs();
    tx_exp.delete(); txgot.delete(); rx_exp.delete(); mgot.delete();
    n_wr = 0; n_rd = 0; n_txinit = 0; n_rxinit = 0; n_done = 0; n_err = 0;
    first_wr_cyc = -1; txinit_cyc = -1; rxinit_cyc = -1; done_cyc = -1; last_beat_cyc = -1;
  endtask

  task automatic fill_src(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w = $urandom();
      src_q.push_back(w);
      tx_exp.push_back(w);
    end
  endtask

  task automatic fill_rx(input int n_load, input int n_exp);
    for (int i = 0; i < n_load; i++) begin
      logic [31:0] w = $urandom();
      rxq.push_back(w);
      if (i < n_exp) rx_exp.push_back(w);
    end
  endtask

  task automatic wait_wr(input string tag, input int n, input int budget);
    int b = 0;
    while (n_wr < n && b < budget) begin step(); b++; end
    chk(tag, n_wr, n);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int b = 0;
    while (n_done == 0 && b < budget) begin step(); b++; end
    chk(tag, n_done, 1);
  endtask

  function automatic int words_of(input int sz, input int cnt);
    return ((sz + 3) / 4) * cnt;
  endfunction

  initial begin
    int s, b, viol;
    rst = 1; tx_start = 0; rx_start = 0; abort = 0; tf_finished = 0;
    block_sz = '0; block_cnt = '0; s_tdata = '0; s_tvalid = 0; m_tready = 0;
    tx_buf_full = 0; rx_buf_empty = 1; rx_buf_dout = '0;
    p_rst = 1; p_tx = 0; p_rx = 0; p_abort = 0; p_tf = 0;
    clear_obs();

    // Reset with an active write stream: everything must read zero.
    fill_src(3);
    repeat (3) step();
    chk("rst_ctrl", {busy, xfer_done, xfer_err, s_tready, m_tvalid, rx_buf_rd_host,
                     tx_buf_wr_host, tx_data_init, rx_data_init}, 0);
    chk("rst_buses", {tx_buf_din, m_tdata}, 0);
    chk("rst_words_left", words_left, 0);
    src_q.delete(); p_rst = 0; step();

    // Write 512x2 bytes, no stalls.
    clear_obs(); block_sz = 512; block_cnt = 2; fill_src(words_of(512, 2));
    p_tx = 1; step(); step();
    chk("t1_words_left", words_left, 256);
    chk("t1_busy", busy, 1);
    wait_wr("t1_writes", 256, 400);
    chk("t1_data", q_diff(txgot, tx_exp), 0);
    chk("t1_txinit_cnt", n_txinit, 1);
    chk("t1_txinit_lag", txinit_cyc - first_wr_cyc, 1);
    repeat (3) step();
    chk("t1_no_early_done", n_done, 0);
    chk("t1_wait_tready", s_tready, 0);
    p_tf = 1; step(); step();
    chk("t1_done", {xfer_done, xfer_err}, 2'b10);
    step();
    chk("t1_idle", {busy, xfer_done}, 0);

    // Write with a 10-cycle full stall and an early tf_finished.
    clear_obs(); block_sz = 128; block_cnt = 1; fill_src(32); valid_pct = 70;
    p_tx = 1; step();
    wait_wr("t2_pre_stall", 10, 100);
    full_force = 1; viol = 0;
    repeat (10) begin step(); if (s_tready !== 1'b0 || tx_buf_wr_host !== 1'b0) viol++; end
    full_force = 0; full_pct = 20;
    chk("t2_stall", viol, 0);
    p_tf = 1;
    wait_wr("t2_writes", 32, 300);
    wait_done("t2_done_latched_tf", 5);
    chk("t2_data", q_diff(txgot, tx_exp), 0);
    chk("t2_err", n_err, 0);
    full_pct = 0; valid_pct = 100; step();

    // Read 16x3 bytes with m_tready toggling.
    clear_obs(); fill_rx(12, 12); ready_mode = 1; block_sz = 16; block_cnt = 3;
    s = cyc; p_rx = 1; step(); step();
    chk("t3_words_left", words_left, 12);
    wait_done("t3_done", 80);
    chk("t3_data", q_diff(mgot, rx_exp), 0);
    chk("t3_rxinit", {n_rxinit[7:0], 8'(rxinit_cyc - s)}, {8'd1, 8'd1});
    chk("t3_done_after_last", done_cyc - last_beat_cyc, 1);
    chk("t3_reads", {n_rd[15:0], n_wr[15:0], n_err[15:0]}, {16'd12, 16'd0, 16'd0});
    step();

    // Read 20 words with 25 available and random ready: no over-read.
    clear_obs(); fill_rx(25, 20); ready_mode = 2; block_sz = 40; block_cnt = 2;
    p_rx = 1; step();
    wait_done("t3b_done", 200);
    chk("t3b_data", q_diff(mgot, rx_exp), 0);
    chk("t3b_reads", {n_rd[15:0], 16'(rxq.size())}, {16'd20, 16'd5});
    rxq.delete(); rd_pend = 0; step();

    // Odd block size rounds up.
    clear_obs(); block_sz = 6; block_cnt = 1; fill_src(2); ready_mode = 0;
    p_tx = 1; step(); step();
    chk("t4_ceil_words", words_left, 2);
    wait_wr("t4_writes", 2, 20);
    p_tf = 1; wait_done("t4_done", 10);
    chk("t4_data", q_diff(txgot, tx_exp), 0);
    step();

    // Zero-length write and read.
    clear_obs(); block_sz = 0; block_cnt = 5; fill_src(3);
    p_tx = 1; step(); step();
    chk("t4_zero_tx_done", {xfer_done, xfer_err}, 2'b11);
    repeat (3) step();
    chk("t4_zero_tx_quiet", {n_wr[7:0], n_txinit[7:0], n_done[7:0]}, {8'd0, 8'd0, 8'd1});
    src_q.delete();
    clear_obs(); block_sz = 100; block_cnt = 0; fill_rx(3, 0);
    p_rx = 1; repeat (5) step();
    chk("t4_zero_rx", {n_rd[7:0], n_rxinit[7:0], n_done[7:0], n_err[7:0]}, {8'd0, 8'd0, 8'd1, 8'd1});
    rxq.delete();

    // Abort a 128-word read after 5 beats with a read in flight, then restart.
    clear_obs(); fill_rx(128, 128); block_sz = 512; block_cnt = 1;
    p_rx = 1; step();
    b = 0;
    while (!(mgot.size() >= 5 && rd_pend) && b < 100) begin step(); b++; end
    chk("t5_reach_abort_point", (mgot.size() >= 5) && rd_pend, 1);
    p_abort = 1; step(); step();
    chk("t5_abort_done", {xfer_done, xfer_err, m_tvalid, rx_buf_rd_host}, 4'b1100);
    step();
    chk("t5_idle", busy, 0);
    clear_obs(); rxq.delete(); rd_pend = 0; fill_rx(8, 8); ready_mode = 2;
    block_sz = 32; block_cnt = 1;
    p_rx = 1; step();
    wait_done("t5_restart_done", 80);
    chk("t5_restart_data", q_diff(mgot, rx_exp), 0);
    chk("t5_restart_flags", {n_err[7:0], n_rxinit[7:0]}, {8'd0, 8'd1});
    step();

    // Reset mid-fill.
    clear_obs(); block_sz = 64; block_cnt = 1; fill_src(16); ready_mode = 0;
    p_tx = 1; step();
    wait_wr("t6_pre_rst", 4, 20);
    p_rst = 1; step(); p_rst = 0; step();
    chk("t6_rst_outputs", {busy, xfer_done, xfer_err, s_tready, tx_buf_wr_host, tx_data_init,
                           m_tvalid, rx_buf_rd_host, rx_data_init}, 0);
    chk("t6_rst_data", {tx_buf_din, words_left}, 0);
    repeat (3) step();
    chk("t6_no_done", n_done, 0);
    src_q.delete(); step();

    // Simultaneous starts, then restarts while busy.
    clear_obs(); fill_rx(4, 0); block_sz = 16; block_cnt = 1; fill_src(4);
    p_tx = 1; p_rx = 1; step();
    wait_wr("t6_sim_pre", 2, 20);
    valid_pct = 0; p_tx = 1; p_rx = 1; step(); step();
    chk("t6_busy_start_ignored", words_left, 28'(4 - n_wr));
    valid_pct = 100;
    wait_wr("t6_sim_writes", 4, 20);
    p_tf = 1; wait_done("t6_sim_done", 10);
    repeat (2) step();
    chk("t6_sim_write_only", {n_rd[7:0], n_rxinit[7:0], 8'(mgot.size()), n_done[7:0]},
        {8'd0, 8'd0, 8'd0, 8'd1});
    chk("t6_sim_data", q_diff(txgot, tx_exp), 0);
    rxq.delete();

    chk("global_m_tdata_stable", stab_viol, 0);
    chk("global_no_underflow", underflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
